gptp_link_emu: RTL

- Single-clock, parametrised point-to-point link emulator for gPTP system tests.
- Accepts frames from a sender port, stamps each with the sender RTC at acceptance, and returns that stamp as the TX timestamp.
- Holds each frame for a runtime-programmable propagation delay, then presents it at the receiver port with the receiver RTC appended.
- Next-generation replacement for the fixed two-node crossing: configurable width, depth and delay, plus queueing under backpressure.

---
 rtl/gptp_pkg.sv | 28 ++
 rtl/gptp_link_fifo.sv | 49 ++++
 rtl/gptp_link_emu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gptp_pkg.sv
// rtl/gptp_pkg.sv - shared timestamp layout and packing helper for the gPTP link emulator
package gptp_pkg;

  localparam int TS_W         = 80;
  localparam int TS_EPOCH_MSB = 79;
  localparam int TS_EPOCH_LSB = 64;
  localparam int TS_SEC_MSB   = 63;
  localparam int TS_SEC_LSB   = 32;
  localparam int TS_NS_MSB    = 31;
  localparam int TS_NS_LSB    = 0;

  typedef struct packed {
    logic [15:0] epoch;
    logic [31:0] sec;
    logic [31:0] nanosec;
  } gptp_ts_t;

  function automatic gptp_ts_t pack_ts(input logic [15:0] epoch,
                                       input logic [31:0] sec,
                                       input logic [31:0] nanosec);
    logic [TS_W-1:0] ts;
    ts[TS_EPOCH_MSB:TS_EPOCH_LSB] = epoch;
    ts[TS_SEC_MSB:TS_SEC_LSB]     = sec;
    ts[TS_NS_MSB:TS_NS_LSB]       = nanosec;
    return gptp_ts_t'(ts);
  endfunction

endpackage

// File: rtl/gptp_link_fifo.sv
// rtl/gptp_link_fifo.sv - synchronous DEPTH-entry FIFO holding {frame, due cycle}
// Head is read from storage, so an entry is never visible in its own push cycle.
module gptp_link_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gptp_link_emu.sv
// rtl/gptp_link_emu.sv - point-to-point gPTP link emulator with per-frame delay and queueing
// Optional periodic frame drop is enabled by defining GPTP_LINK_DROP_EN.
module gptp_link_emu
  import gptp_pkg::*;
#(
  parameter int DATA_W      = 352,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int DELAY_W     = 8,
  parameter int DROP_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_W-1:0]     cfg_delay,
  input  logic                   gptp_ts_vaild,
  output logic                   gptp_ts_ready,
  input  logic [DATA_W-1:0]      gptp_ts_data,
  output logic                   gptp_ts_rv_vaild,
  output logic [TS_W-1:0]        gptp_ts_rv_data,
  input  logic [31:0]            rtc_nanosec_field_sd,
  input  logic [31:0]            rtc_sec_field_sd,
  input  logic [15:0]            rtc_epoch_field_sd,
  input  logic [31:0]            rtc_nanosec_field_rv,
  input  logic [31:0]            rtc_sec_field_rv,
  input  logic [15:0]            rtc_epoch_field_rv,
  output logic [DATA_W+TS_W-1:0] gptp_rv_data,
  output logic                   gptp_rv_vaild,
  input  logic                   gptp_rv_ready,
  output logic [15:0]            drop_cnt
);

  localparam int ENTRY_W = DATA_W + CNT_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DROP_PERIOD < 1) begin : g_bad_param
    $error("gptp_link_emu: DEPTH must be a power of 2 >= 2 and DROP_PERIOD >= 1");
  end

  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic                   fifo_full, fifo_empty;
  logic                   accept, drop, push, pop, head_due;
  logic [ENTRY_W-1:0]     head_entry;
  logic [DATA_W-1:0]      head_data;
  logic [CNT_W-1:0]       head_due_cyc, elapsed;
  logic                   ts_vld_q, ts_vld_d;
  gptp_ts_t               ts_data_q, ts_data_d;
  logic                   rv_vld_q, rv_vld_d;
  logic [DATA_W+TS_W-1:0] rv_data_q, rv_data_d;

  assign gptp_ts_ready = !fifo_full;
  assign accept        = gptp_ts_vaild && !fifo_full;
  assign push          = accept && !drop;

  // Wrap-safe: the head is due once (cyc - due) lands in the lower half of the counter range.
  assign {head_data, head_due_cyc} = head_entry;
  assign elapsed  = cyc_q - head_due_cyc;
  assign head_due = !elapsed[CNT_W-1];
  assign pop      = !fifo_empty && head_due && (!rv_vld_q || gptp_rv_ready);

  gptp_link_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({gptp_ts_data, cyc_q + CNT_W'(cfg_delay)}),
    .pop     (pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    cyc_d     = cyc_q + CNT_W'(1);
    ts_vld_d  = accept;
    ts_data_d = ts_data_q;
    if (accept) ts_data_d = pack_ts(rtc_epoch_field_sd, rtc_sec_field_sd, rtc_nanosec_field_sd);
    rv_vld_d  = rv_vld_q;
    rv_data_d = rv_data_q;
    if (pop) begin
      rv_vld_d  = 1'b1;
      rv_data_d = {head_data, pack_ts(rtc_epoch_field_rv, rtc_sec_field_rv, rtc_nanosec_field_rv)};
    end else if (gptp_rv_ready) begin
      rv_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      ts_vld_q  <= 1'b0;
      ts_data_q <= '0;
      rv_vld_q  <= 1'b0;
      rv_data_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      ts_vld_q  <= ts_vld_d;
      ts_data_q <= ts_data_d;
      rv_vld_q  <= rv_vld_d;
      rv_data_q <= rv_data_d;
    end
  end

  assign gptp_ts_rv_vaild = ts_vld_q;
  assign gptp_ts_rv_data  = ts_data_q;
  assign gptp_rv_vaild    = rv_vld_q;
  assign gptp_rv_data     = rv_data_q;

`ifdef GPTP_LINK_DROP_EN
  localparam int PW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;

  logic [PW-1:0] acc_cnt_q, acc_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  // Dropped frames still count as accepted so the sender sees its TX stamp.
  assign drop = accept && (acc_cnt_q == PW'(DROP_PERIOD - 1));

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) acc_cnt_d = drop ? '0 : acc_cnt_q + PW'(1);
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop     = 1'b0;
  assign drop_cnt = 16'h0000;
`endif

endmodule
